// File: rtl/key_filter_pkg.sv
// Shared state encoding and 50 MHz default timing constants for the key filter.
// Latency: n/a. Backpressure: n/a.
package key_filter_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_st_e;

  // 20 ms debounce window and 1 s long-press threshold at 50 MHz
  localparam int unsigned CNT_MAX_50M  = 32'd999_999;
  localparam int unsigned LONG_MAX_50M = 32'd49_999_999;

endpackage

// File: rtl/key_filter_chan.sv
// One key channel: 2-flop sync, debounce FSM, long-press timer, registered outputs.
// Latency: press/release CNT_MAX+2 cycles after a clean pin edge. Backpressure: none.
module key_filter_chan
  import key_filter_pkg::*;
#(
  parameter int unsigned CNT_MAX    = CNT_MAX_50M,
  parameter int unsigned LONG_MAX   = LONG_MAX_50M,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic key_i,
  output logic state_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned LW = $clog2(LONG_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CNT_MAX - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [LW-1:0] LONG_LAST = LW'(LONG_MAX - 1);
  localparam logic [LW-1:0] LONG_TOP  = LW'(LONG_MAX);
  localparam logic          REL_LVL   = ACTIVE_LOW;

  logic [1:0]    sync_q;
  logic          pressed;
  key_st_e       state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] long_q, long_d;
  logic          key_state_q, key_state_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_p_q, long_p_d;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) sync_q <= {2{REL_LVL}};
    else          sync_q <= {sync_q[0], key_i};
  end

  assign pressed = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    long_d      = long_q;
    key_state_d = key_state_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_p_d    = 1'b0;

    // Long timer runs through release bounce so a shaky hold still times out
    if (state_q == DOWN || state_q == REL_FILT) begin
      if (long_q != LONG_TOP)  long_d   = long_q + 1'b1;
      if (long_q == LONG_LAST) long_p_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (pressed) begin
          state_d = PRESS_FILT;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = '0;
        end
      end
      PRESS_FILT: begin
        if (!pressed) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = DOWN;
          cnt_d       = '0;
          long_d      = '0;
          press_d     = 1'b1;
          key_state_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (!pressed) begin
          state_d = REL_FILT;
          cnt_d   = CNT_ONE;
        end
      end
      REL_FILT: begin
        if (pressed) begin
          state_d = DOWN;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = IDLE;
          cnt_d       = '0;
          release_d   = 1'b1;
          key_state_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      long_q      <= '0;
      key_state_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_p_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      long_q      <= long_d;
      key_state_q <= key_state_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_p_q    <= long_p_d;
    end
  end

  assign state_o   = key_state_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_p_q;

endmodule

// File: rtl/key_filter_multi.sv
// KEY_NUM independent debounced keys with level, press, release and long-press pulses.
// Latency: CNT_MAX+2 cycles pin to pulse. Backpressure: none.
module key_filter_multi
  import key_filter_pkg::*;
#(
  parameter int unsigned KEY_NUM    = 4,
  parameter int unsigned CNT_MAX    = CNT_MAX_50M,
  parameter int unsigned LONG_MAX   = LONG_MAX_50M,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_state,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_long
);

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_chan
    key_filter_chan #(
      .CNT_MAX   (CNT_MAX),
      .LONG_MAX  (LONG_MAX),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_chan (
      .clk_i    (sys_clk),
      .rst_n_i  (sys_rst_n),
      .key_i    (key_in[g]),
      .state_o  (key_state[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g])
    );
  end

endmodule

// File: tb/tb_key_filter_multi.sv
// Bench for key_filter_multi: run-length reference model checked every cycle,
// plus directed scenarios with hand-computed timing literals.
module tb_key_filter_multi;

  localparam int NK   = 4;
  localparam int CMAX = 20;
  localparam int LMAX = 100;

  logic          sys_clk;
  logic          sys_rst_n;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state, key_press, key_release, key_long;

  key_filter_multi #(
    .KEY_NUM   (NK),
    .CNT_MAX   (CMAX),
    .LONG_MAX  (LMAX),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: accepted level flips after CMAX consecutive samples of the
  // opposite pressed-value; long fires when time since press reaches LMAX.
  logic [NK-1:0] m_s1, m_s2, m_lvl;
  logic [NK-1:0] e_state, e_press, e_rel, e_long;
  int            m_run[NK];
  int            m_since[NK];
  logic          m_p;
  bit            mvalid = 0;

  always @(posedge sys_clk) begin
    cyc++;
    for (int ch = 0; ch < NK; ch++) begin
      e_press[ch] = 1'b0;
      e_rel[ch]   = 1'b0;
      e_long[ch]  = 1'b0;
      if (!sys_rst_n) begin
        m_s1[ch] = 1'b1;  m_s2[ch] = 1'b1;  m_lvl[ch] = 1'b0;
        m_run[ch] = 0;    m_since[ch] = 0;
      end else begin
        m_p      = ~m_s2[ch];
        m_s2[ch] = m_s1[ch];
        m_s1[ch] = key_in[ch];
        if (!m_lvl[ch]) begin
          m_run[ch] = m_p ? m_run[ch] + 1 : 0;
          if (m_run[ch] == CMAX) begin
            m_lvl[ch] = 1'b1; m_run[ch] = 0; m_since[ch] = 0; e_press[ch] = 1'b1;
          end
        end else begin
          if (m_since[ch] < LMAX) begin
            m_since[ch]++;
            if (m_since[ch] == LMAX) e_long[ch] = 1'b1;
          end
          m_run[ch] = m_p ? 0 : m_run[ch] + 1;
          if (m_run[ch] == CMAX) begin
            m_lvl[ch] = 1'b0; m_run[ch] = 0; e_rel[ch] = 1'b1;
          end
        end
      end
    end
    e_state = m_lvl;
    if (!sys_rst_n) mvalid = 1;
  end

  // Event log observed from the DUT, used by the directed timing checks
  int   press_n[NK], rel_n[NK], long_n[NK], rise_n[NK], fall_n[NK];
  int   press_cyc[NK], rel_cyc[NK], long_cyc[NK];
  bit   all_press_seen;
  logic [NK-1:0] prev_state = '0;

  always @(negedge sys_clk) begin
    if (mvalid) begin
      chk("key_state",   32'(key_state),   32'(e_state));
      chk("key_press",   32'(key_press),   32'(e_press));
      chk("key_release", 32'(key_release), 32'(e_rel));
      chk("key_long",    32'(key_long),    32'(e_long));
      for (int ch = 0; ch < NK; ch++) begin
        if (key_press[ch] === 1'b1)   begin press_n[ch]++; press_cyc[ch] = cyc; end
        if (key_release[ch] === 1'b1) begin rel_n[ch]++;   rel_cyc[ch]   = cyc; end
        if (key_long[ch] === 1'b1)    begin long_n[ch]++;  long_cyc[ch]  = cyc; end
        if (key_state[ch] === 1'b1 && prev_state[ch] === 1'b0) rise_n[ch]++;
        if (key_state[ch] === 1'b0 && prev_state[ch] === 1'b1) fall_n[ch]++;
      end
      if (key_press === 4'hF) all_press_seen = 1;
      prev_state = key_state;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic clr_stats();
    for (int ch = 0; ch < NK; ch++) begin
      press_n[ch] = 0; rel_n[ch] = 0; long_n[ch] = 0; rise_n[ch] = 0; fall_n[ch] = 0;
      press_cyc[ch] = 0; rel_cyc[ch] = 0; long_cyc[ch] = 0;
    end
    all_press_seen = 0;
  endtask

  int            c0, c1;
  logic [14:0]   pat15;
  logic [9:0]    pat10;

  initial begin
    sys_rst_n = 1'b0;
    key_in    = '1;
    clr_stats();
    tick(3);
    chk("rst_state",   32'(key_state),   0);
    chk("rst_press",   32'(key_press),   0);
    chk("rst_release", 32'(key_release), 0);
    chk("rst_long",    32'(key_long),    0);
    sys_rst_n = 1'b1;
    tick(5);

    // Clean press held 200 cycles
    clr_stats();
    key_in[0] = 1'b0; c0 = cyc;
    tick(200);
    key_in[0] = 1'b1; c1 = cyc;
    tick(40);
    chk("t1_press_n",     press_n[0], 1);
    chk("t1_press_lat",   press_cyc[0] - c0, 22);
    chk("t1_long_n",      long_n[0], 1);
    chk("t1_long_lat",    long_cyc[0] - press_cyc[0], 100);
    chk("t1_rel_n",       rel_n[0], 1);
    chk("t1_rel_lat",     rel_cyc[0] - c1, 22);

    // Press with 15 cycles of bounce, timed from the final falling edge
    clr_stats();
    pat15 = 15'b110_0101_1011_0100;
    for (int i = 0; i < 15; i++) begin
      key_in[0] = pat15[i];
      tick(1);
    end
    key_in[0] = 1'b0; c0 = cyc;
    tick(60);
    key_in[0] = 1'b1;
    tick(40);
    chk("t2_press_n",   press_n[0], 1);
    chk("t2_press_lat", press_cyc[0] - c0, 22);
    chk("t2_rel_n",     rel_n[0], 1);
    chk("t2_long_n",    long_n[0], 0);

    // 19-cycle glitch is rejected, 20-cycle pulse is accepted
    clr_stats();
    key_in[0] = 1'b0;
    tick(19);
    key_in[0] = 1'b1;
    tick(30);
    chk("t3_short_press_n", press_n[0], 0);
    chk("t3_short_rise_n",  rise_n[0], 0);
    key_in[0] = 1'b0;
    tick(20);
    key_in[0] = 1'b1;
    tick(40);
    chk("t3_min_press_n", press_n[0], 1);
    chk("t3_min_rel_n",   rel_n[0], 1);

    // 60-cycle hold then release bounce: no long, one release
    clr_stats();
    key_in[0] = 1'b0;
    tick(60);
    pat10 = 10'b01_1001_1011;
    for (int i = 0; i < 10; i++) begin
      key_in[0] = pat10[i];
      tick(1);
    end
    key_in[0] = 1'b1; c1 = cyc;
    tick(40);
    chk("t4_press_n", press_n[0], 1);
    chk("t4_long_n",  long_n[0], 0);
    chk("t4_rel_n",   rel_n[0], 1);
    chk("t4_rel_lat", rel_cyc[0] - c1, 22);
    chk("t4_fall_n",  fall_n[0], 1);

    // All keys pressed together, released staggered by 5 cycles
    clr_stats();
    key_in = 4'b0000; c0 = cyc;
    tick(50);
    for (int ch = 0; ch < NK; ch++) begin
      key_in[ch] = 1'b1;
      tick(5);
    end
    tick(40);
    chk("t5_all_press",  32'(all_press_seen), 1);
    chk("t5_press_lat3", press_cyc[3] - c0, 22);
    chk("t5_rel_gap01",  rel_cyc[1] - rel_cyc[0], 5);
    chk("t5_rel_gap12",  rel_cyc[2] - rel_cyc[1], 5);
    chk("t5_rel_gap23",  rel_cyc[3] - rel_cyc[2], 5);
    chk("t5_long_n",     long_n[0] + long_n[1] + long_n[2] + long_n[3], 0);

    // Reset while key 2 is down: outputs clear without a release pulse
    clr_stats();
    key_in[2] = 1'b0;
    tick(30);
    chk("t6_state_before", 32'(key_state[2]), 1);
    sys_rst_n = 1'b0;
    tick(1);
    chk("t6_rst_state", 32'(key_state), 0);
    chk("t6_rst_pulse", 32'({key_press, key_release, key_long}), 0);
    sys_rst_n = 1'b1; c0 = cyc;
    tick(40);
    chk("t6_press_n",   press_n[2], 2);
    chk("t6_press_lat", press_cyc[2] - c0, 22);
    chk("t6_rel_n",     rel_n[2], 0);
    key_in[2] = 1'b1;
    tick(40);
    chk("t6_rel_after", rel_n[2], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
